// File: rtl/recover_2n_feeder.sv
// Feeds buffered column pairs to the recover stage one beat per cycle, counts the
// results that come back, and reports the end of the frame or a protocol error.
module recover_2n_feeder #(
    parameter int unsigned DATA_WIDTH = 27,
    parameter int unsigned NUM_BEATS  = 1024,
    parameter int unsigned LATENCY    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      pause,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      rd_en,
    output logic [9:0]                rd_addr,
    input  logic [16*DATA_WIDTH-1:0]  rd_col1,
    input  logic [16*DATA_WIDTH-1:0]  rd_col2,
    output logic                      valid,
    output logic [10:0]               index_col_1,
    output logic [10:0]               index_col_2,
    output logic [16*DATA_WIDTH-1:0]  out_col1,
    output logic [16*DATA_WIDTH-1:0]  out_col2,
    input  logic                      fft_ready
);

    localparam int unsigned W = 16 * DATA_WIDTH;

    localparam logic [10:0] LastBeat  = 11'(NUM_BEATS - 1);
    localparam logic [11:0] BeatTotal = 12'(NUM_BEATS);
    localparam logic [10:0] WdLimit   = 11'(LATENCY + 4);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] issue_q, issue_d;
    logic [10:0] ret_q, ret_d;
    logic [10:0] wd_q, wd_d;
    logic        err_q, err_d;

    logic         valid_q;
    logic [10:0]  idx1_q, idx2_q;
    logic [W-1:0] hold1_q, hold2_q;

    logic [10:0] ret_sat;
    logic [10:0] wd_sat;
    logic [11:0] ret_with_now;

    // Control state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            issue_q <= '0;
            ret_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic, counters and the sticky error flag
    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        ret_d        = ret_q;
        wd_d         = wd_q;
        err_d        = err_q;
        ret_sat      = (ret_q == '1) ? ret_q : ret_q + 11'd1;
        wd_sat       = (wd_q == '1) ? wd_q : wd_q + 11'd1;
        ret_with_now = {1'b0, ret_q} + {11'd0, fft_ready};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    issue_d = '0;
                    ret_d   = '0;
                    wd_d    = '0;
                    err_d   = 1'b0;
                end else if (fft_ready) begin
                    err_d = 1'b1;
                end
            end
            StRun: begin
                if (!pause) begin
                    issue_d = issue_q + 11'd1;
                    if (issue_q == LastBeat) begin
                        state_d = StDrain;
                    end
                end
                if (fft_ready) begin
                    ret_d = ret_sat;
                    // A return with nothing outstanding is a protocol violation.
                    if (ret_q >= issue_q) begin
                        err_d = 1'b1;
                    end
                end
                wd_d = valid_q ? 11'd1 : wd_sat;
            end
            StDrain: begin
                if (fft_ready) begin
                    ret_d = ret_sat;
                    if (ret_q >= issue_q) begin
                        err_d = 1'b1;
                    end
                end
                wd_d = valid_q ? 11'd1 : wd_sat;
                if (ret_with_now >= BeatTotal) begin
                    state_d = StDone;
                end else if (!valid_q && (wd_sat >= WdLimit)) begin
                    // Results stopped arriving: give up on the frame.
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (fft_ready) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat pipeline: valid and indices follow the read strobe by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx1_q  <= '0;
            idx2_q  <= '0;
            hold1_q <= '0;
            hold2_q <= '0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                idx1_q <= {rd_addr, 1'b0};
                idx2_q <= {rd_addr, 1'b1};
            end
            if (valid_q) begin
                hold1_q <= rd_col1;
                hold2_q <= rd_col2;
            end
        end
    end

    // Outputs; data passes straight through on a valid beat and holds otherwise
    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        err         = err_q;
        rd_en       = (state_q == StRun) && !pause;
        rd_addr     = issue_q[9:0];
        valid       = valid_q;
        index_col_1 = idx1_q;
        index_col_2 = idx2_q;
        out_col1    = valid_q ? rd_col1 : hold1_q;
        out_col2    = valid_q ? rd_col2 : hold2_q;
    end

endmodule

// File: tb/tb_recover_2n_feeder.sv
// Directed bench for recover_2n_feeder with a scoreboard on the beat outputs.
module tb_recover_2n_feeder;

    localparam int DW  = 8;
    localparam int NB  = 4;
    localparam int LAT = 8;
    localparam int W   = 16 * DW;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         pause;
    logic         busy;
    logic         done;
    logic         err;
    logic         rd_en;
    logic [9:0]   rd_addr;
    logic [W-1:0] rd_col1;
    logic [W-1:0] rd_col2;
    logic         valid;
    logic [10:0]  index_col_1;
    logic [10:0]  index_col_2;
    logic [W-1:0] out_col1;
    logic [W-1:0] out_col2;
    logic         fft_ready;

    logic [8:0]   sr;
    logic         loop_en;
    logic         man_rdy;

    int n_vec;
    int n_err;

    typedef struct {
        logic [10:0]  i1;
        logic [10:0]  i2;
        logic [W-1:0] c1;
        logic [W-1:0] c2;
    } exp_t;

    exp_t sb[$];

    recover_2n_feeder #(
        .DATA_WIDTH (DW),
        .NUM_BEATS  (NB),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_col1     (rd_col1),
        .rd_col2     (rd_col2),
        .valid       (valid),
        .index_col_1 (index_col_1),
        .index_col_2 (index_col_2),
        .out_col1    (out_col1),
        .out_col2    (out_col2),
        .fft_ready   (fft_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat1(input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'hA5;
        return {16{b}};
    endfunction

    function automatic logic [W-1:0] pat2(input int a);
        logic [7:0] b;
        b = 8'(a) + 8'h3C;
        return {16{b}};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Buffer model with one-cycle read latency; junk when not reading
    always @(posedge clk) begin
        if (rd_en) begin
            rd_col1 <= pat1(int'(rd_addr));
            rd_col2 <= pat2(int'(rd_addr));
        end else begin
            rd_col1 <= {16{8'hEE}};
            rd_col2 <= {16{8'hEE}};
        end
    end

    // Recover stage stand-in: returns each valid beat 8 cycles later
    initial sr = '0;
    always @(negedge clk) sr = {sr[7:0], valid};
    assign fft_ready = (loop_en & sr[8]) | man_rdy;

    // Monitor: every valid beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 idx=%0d, expected no beat",
                         index_col_1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("index_col_1", W'(index_col_1), W'(e.i1));
                chk("index_col_2", W'(index_col_2), W'(e.i2));
                chk("out_col1", out_col1, e.c1);
                chk("out_col2", out_col2, e.c2);
            end
        end
    end

    task automatic push_frame();
        for (int a = 0; a < NB; a++) begin
            sb.push_back('{i1: 11'(2 * a), i2: 11'(2 * a + 1), c1: pat1(a), c2: pat2(a)});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_err"}, W'(err), '0);
        chk({tag, "_rd_en"}, W'(rd_en), '0);
        chk({tag, "_rd_addr"}, W'(rd_addr), '0);
        chk({tag, "_valid"}, W'(valid), '0);
        chk({tag, "_index_col_1"}, W'(index_col_1), '0);
        chk({tag, "_index_col_2"}, W'(index_col_2), '0);
        chk({tag, "_out_col1"}, out_col1, '0);
        chk({tag, "_out_col2"}, out_col2, '0);
    endtask

    // Advance until done (bounded) and compare the cycle it appeared on
    task automatic wait_done(input string tag, input int c_now, input int exp_c);
        int c;
        c = c_now;
        while (c < exp_c + 30) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (done) break;
        end
        chk({tag, "_done_cycle"}, W'(c), W'(exp_c));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] en_tab;
        logic [6:0] vld_tab;
        int         addr_tab[7];
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        loop_en = 1'b0;
        man_rdy = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Plain frame with loopback returns
        @(negedge clk);
        loop_en = 1'b1;
        push_frame();
        start = 1'b1;
        for (int c = 1; c <= NB; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("t1_rd_en", W'(rd_en), W'(1));
            chk("t1_rd_addr", W'(rd_addr), W'(c - 1));
            chk("t1_busy", W'(busy), W'(1));
        end
        wait_done("t1", NB, 14);
        chk("t1_err", W'(err), '0);
        @(negedge clk);
        chk("t1_done_pulse", W'(done), '0);
        chk("t1_idle", W'(busy), '0);
        chk("t1_hold_col1", out_col1, pat1(3));
        chk("t1_hold_idx2", W'(index_col_2), W'(7));
        chk("t1_sb_empty", W'(sb.size()), '0);

        // Pause for three cycles after beat 1
        en_tab   = 7'b1100011;
        vld_tab  = 7'b1000110;
        addr_tab = '{0, 1, 2, 2, 2, 2, 3};
        @(negedge clk);
        push_frame();
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            pause = (c >= 3 && c <= 5);
            #1;
            chk("t2_rd_en", W'(rd_en), W'(en_tab[c - 1]));
            chk("t2_rd_addr", W'(rd_addr), W'(addr_tab[c - 1]));
            chk("t2_valid", W'(valid), W'(vld_tab[c - 1]));
        end
        pause = 1'b0;
        wait_done("t2", 7, 17);
        chk("t2_err", W'(err), '0);

        // No returns: watchdog fires LATENCY+4 after the last valid (cycle 5)
        @(negedge clk);
        loop_en = 1'b0;
        push_frame();
        start = 1'b1;
        wait_done("t3", 0, 5 + LAT + 4);
        chk("t3_err_at_done", W'(err), W'(1));
        @(negedge clk);
        chk("t3_idle", W'(busy), '0);
        chk("t3_err_sticky", W'(err), W'(1));
        chk("t3_sb_empty", W'(sb.size()), '0);
        repeat (12) @(negedge clk);

        // Start during RUN is ignored; stray ready in IDLE raises err
        loop_en = 1'b1;
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_err_cleared", W'(err), '0);
        chk("t4_rd_addr0", W'(rd_addr), W'(0));
        @(negedge clk);
        chk("t4_rd_addr1", W'(rd_addr), W'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_rd_addr2", W'(rd_addr), W'(2));
        wait_done("t4", 3, 14);
        chk("t4_err", W'(err), '0);
        @(negedge clk);
        man_rdy = 1'b1;
        @(negedge clk);
        man_rdy = 1'b0;
        chk("t4_stray_err", W'(err), W'(1));
        chk("t4_stray_idle", W'(busy), '0);
        @(negedge clk);
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_restart_clears_err", W'(err), '0);
        wait_done("t4b", 1, 14);
        chk("t4b_err", W'(err), '0);
        repeat (12) @(negedge clk);

        // Reset in the middle of a frame
        loop_en = 1'b0;
        push_frame();
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_reset");
        chk("t5_beats_before_reset", W'(sb.size()), W'(2));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t5_quiet", W'({valid, done, busy}), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/recover_2n_feeder.md
RECOVER_2N_FEEDER -- requirements
Module: recover_2n_feeder

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 27, per-component sample width.
- REQ-002 SHALL have parameter NUM_BEATS, default 1024, beats per frame; legal range 1..1024.
- REQ-003 SHALL have parameter LATENCY, default 8, the fixed consumer latency from valid to ready.
- REQ-004 SHALL have port clk, input, 1, the single clock.
- REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
- REQ-006 SHALL have port start, input, 1, frame start pulse.
- REQ-007 SHALL have port pause, input, 1, inhibits issue of new beats.
- REQ-008 SHALL have port busy, output, 1, high in any state except IDLE.
- REQ-009 SHALL have port done, output, 1, one-cycle end-of-frame pulse.
- REQ-010 SHALL have port err, output, 1, sticky protocol error flag.
- REQ-011 SHALL have port rd_en, output, 1, buffer read strobe.
- REQ-012 SHALL have port rd_addr, output, 10, buffer read address.
- REQ-013 SHALL have ports rd_col1 and rd_col2, input, 16*DATA_WIDTH each, buffer data returned one cycle after rd_en; layout {x2_i, x2_r, x1_i, x1_r}, 4 lanes each, lane 0 in the LSBs.
- REQ-014 SHALL have port valid, output, 1, beat valid to the recover stage.
- REQ-015 SHALL have ports index_col_1 and index_col_2, output, 11 each, beat indices.
- REQ-016 SHALL have ports out_col1 and out_col2, output, 16*DATA_WIDTH each, beat data in the same layout as rd_col1 and rd_col2.
- REQ-017 SHALL have port fft_ready, input, 1, result strobe from the recover stage.

Function
- REQ-018 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
- REQ-019 IDLE SHALL go to RUN when start=1 and SHALL clear err, the issue counter and the return counter.
- REQ-020 start SHALL be ignored in every state other than IDLE.
- REQ-021 In RUN, each cycle with pause=0 SHALL assert rd_en with rd_addr equal to the issue counter, then increment the issue counter; a cycle with pause=1 SHALL assert no rd_en and leave the counter unchanged.
- REQ-022 The cycle after a rd_en, the block SHALL assert valid, drive out_colN with rd_colN unmodified, index_col_1 = {rd_addr,0} and index_col_2 = {rd_addr,1} using the registered address; valid SHALL be 0 otherwise.
- REQ-023 Read-to-valid latency SHALL be exactly 1 cycle; out_col and index outputs SHALL hold their last values while valid=0.
- REQ-024 RUN SHALL go to DRAIN in the cycle that issues beat NUM_BEATS-1.
- REQ-025 Each fft_ready=1 cycle SHALL increment the return counter.
- REQ-026 DRAIN SHALL go to DONE when the return counter reaches NUM_BEATS, including a return in the same cycle.
- REQ-027 DRAIN SHALL run a watchdog that counts cycles since the last valid; reaching LATENCY+4 SHALL set err and force DONE.
- REQ-028 An fft_ready in IDLE or DONE, or a return count exceeding the issued count, SHALL set err and SHALL NOT change state.
- REQ-029 DONE SHALL assert done for exactly one cycle and then go to IDLE.
- REQ-030 pause SHALL have no effect in DRAIN or DONE.
- REQ-031 All counters SHALL be 11 bits wide and SHALL NOT wrap within a frame.

Reset
- REQ-032 rst_n=0 SHALL immediately force IDLE, all counters to 0, and all outputs to 0: busy, done, err, rd_en, rd_addr, valid, index_col_1, index_col_2, out_col1, out_col2.
- REQ-033 Reset asserted mid-frame SHALL abandon the frame; no valid or done SHALL follow deassertion until a new start.

Verification
- REQ-034 NUM_BEATS=4, start, no pause, fft_ready looped back at 8-cycle delay -> rd_addr 0..3 on cycles 1..4; valid on cycles 2..5 with index pairs (0,1),(2,3),(4,5),(6,7); done one cycle after the 4th return; err=0.
- REQ-035 NUM_BEATS=4, pause high for 3 cycles after beat 1 -> rd_en gap of 3 cycles; valid gap of 3 cycles; indices unchanged; done still produced.
- REQ-036 fft_ready tied low after frame issue -> err=1 and done pulse LATENCY+4 cycles after the last valid; state returns to IDLE.
- REQ-037 start pulsed during RUN, plus fft_ready pulse in IDLE -> second start ignored; err=1 from the stray ready; next legal start clears err.
- REQ-038 rst_n pulsed low at beat 2 of a 1024-beat frame -> all outputs 0 within the reset cycle; no valid after release until start.
